image_loader: RTL and testbench
===============================

IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter N_PIXELS, default 784, number of pixels per frame.
REQ-002 SHALL have parameter FRAC_BITS, default 8, fractional bits of the stored fixed-point pixel; legal range 8..23.
REQ-003 SHALL have parameter THRESH, default 128, binarization threshold; used only under REQ-025.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pix_valid  input  1  pixel offered.
REQ-007 SHALL have port pix_ready  output  1  loader accepts pixel.
REQ-008 SHALL have port pix_data  input  8  unsigned pixel intensity.
REQ-009 SHALL have port pix_last  input  1  sender's end-of-frame marker.
REQ-010 SHALL have port mem_addr  output  16  image memory write address.
REQ-011 SHALL have port mem_data  output  32  signed fixed-point pixel word.
REQ-012 SHALL have port mem_we  output  1  image memory write enable.
REQ-013 SHALL have port nn_start  output  1  one-cycle start pulse to the network.
REQ-014 SHALL have ports nn_done  input  1, and nn_argmax  input  4: network completion and class index.
REQ-015 SHALL have ports result  output  4, result_valid  output  1, busy  output  1, frame_error  output  1: latched class, class valid, inference in flight, one-cycle malformed-frame pulse.

Function
REQ-016 SHALL implement states LOAD, KICK, WAIT; only LOAD asserts pix_ready=1.
REQ-017 In LOAD, a handshake (pix_valid and pix_ready) SHALL occur each cycle both are high; each accepted pixel SHALL increment a pixel counter cnt (0..N_PIXELS-1).
REQ-018 A pixel accepted at cycle T SHALL be written at T+1: mem_we=1, mem_addr=cnt at acceptance, mem_data=conversion of pix_data; mem_we=0 otherwise.
REQ-019 Conversion: mem_data = pix_data zero-extended, shifted left by FRAC_BITS-8; result always non-negative.
REQ-020 Accepting the pixel with cnt=N_PIXELS-1 SHALL move LOAD->KICK; pix_last on that pixel is optional; pix_ready=0 from the next cycle.
REQ-021 KICK SHALL be entered the cycle after the last write, assert nn_start=1 for exactly one cycle, then go to WAIT; busy=1 in KICK and WAIT.
REQ-022 In WAIT, nn_done=1 SHALL latch result<=nn_argmax, set result_valid=1, clear cnt, return to LOAD next cycle; nn_done outside WAIT SHALL be ignored.
REQ-023 pix_last accepted with cnt<N_PIXELS-1 SHALL pulse frame_error=1 the next cycle, still write that pixel, reset cnt to 0, remain in LOAD, issue no nn_start.
REQ-024 result_valid SHALL clear on the first pixel accepted of a new frame; result holds its value until overwritten.

Configuration
REQ-025 With macro IMAGE_LOADER_BINARIZE_EN defined, mem_data SHALL be (1 shl FRAC_BITS) when pix_data>=THRESH, else 0; without it, REQ-019 applies and THRESH is unused.

Reset
REQ-026 reset=1 at a clock edge SHALL force LOAD, cnt=0, pix_ready=1 on the following cycle, mem_we=0, nn_start=0, result=0, result_valid=0, busy=0, frame_error=0.
REQ-027 reset mid-frame or in WAIT SHALL abandon the frame; a later nn_done from the aborted inference SHALL be ignored per REQ-022.
REQ-028 reset has priority over every simultaneous event.

Verification
REQ-029 Stream 784 pixels, all 0xFF, no stalls -> 784 writes at addr 0..783, data 0x000000FF; nn_start pulses once, 2 cycles after the last handshake.
REQ-030 WAIT, nn_done=1, nn_argmax=7 -> result=7, result_valid=1, pix_ready=1 the next cycle; a second nn_done later -> no change.
REQ-031 pix_last on pixel 10 (cnt=9) -> frame_error one-cycle pulse, no nn_start, next frame writes from addr 0.
REQ-032 pix_valid toggled 50% random with pix_data=addr mod 256 -> memory contents match, no duplicate or missing addresses.
REQ-033 reset asserted after 400 pixels -> next frame starts at addr 0; with IMAGE_LOADER_BINARIZE_EN, pixels 127/128 -> mem_data 0/0x100.
REQ-034 In WAIT, pix_valid held 1 -> pix_ready stays 0 and mem_we stays 0 until return to LOAD.

Source files
------------

// File: rtl/image_loader_if.sv
// ---------------------------------------------------------------------------
// image_loader_if
//
// Groups the pixel stream handshake and the image-memory write bus of the
// image loader into one bundle.
//
//   pix_valid  sender -> loader   pixel offered
//   pix_ready  loader -> sender   loader accepts pixel
//   pix_data   sender -> loader   8-bit unsigned intensity
//   pix_last   sender -> loader   sender's end-of-frame marker
//   mem_addr   loader -> memory   16-bit write address
//   mem_data   loader -> memory   32-bit signed fixed-point pixel word
//   mem_we     loader -> memory   write enable
//
// Modports:
//   master : the pixel source / memory observer side (e.g. a testbench)
//   slave  : the image loader itself
// ---------------------------------------------------------------------------
interface image_loader_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        pix_last;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_last,
        input  pix_ready,
        input  mem_addr,
        input  mem_data,
        input  mem_we
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_last,
        output pix_ready,
        output mem_addr,
        output mem_data,
        output mem_we
    );
endinterface

// File: rtl/image_loader.sv
// ---------------------------------------------------------------------------
// image_loader
//
// Receives a frame of N_PIXELS 8-bit pixels over a valid/ready stream,
// converts each pixel to a 32-bit signed fixed-point word and writes it to
// the image memory one cycle after acceptance. When the last pixel of a
// frame has been written, the loader pulses nn_start, waits for nn_done and
// latches the network's class index into result.
//
// Parameters:
//   N_PIXELS   pixels per frame (default 784)
//   FRAC_BITS  fractional bits of the stored pixel word, 8..23 (default 8)
//   THRESH     binarization threshold, only meaningful with the
//              IMAGE_LOADER_BINARIZE_EN build option (default 128)
//
// Build option:
//   IMAGE_LOADER_BINARIZE_EN  when defined, each stored word is 1.0 in
//                             fixed point (1 << FRAC_BITS) for pixels at or
//                             above THRESH and 0 otherwise. When undefined,
//                             the pixel is zero-extended and shifted left by
//                             FRAC_BITS-8.
//
// Ports:
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   bus           image_loader_if.slave: pixel stream + memory write bus
//   nn_start      one-cycle start pulse to the network
//   nn_done       network completion (honoured only while waiting)
//   nn_argmax     class index reported by the network
//   result        latched class index
//   result_valid  result belongs to the most recent completed frame
//   busy          inference in flight (KICK or WAIT)
//   frame_error   one-cycle pulse: pix_last arrived before the frame was full
// ---------------------------------------------------------------------------
module image_loader #(
    parameter int N_PIXELS  = 784,
    parameter int FRAC_BITS = 8,
    parameter int THRESH    = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    image_loader_if.slave        bus,
    output logic                 nn_start,
    input  logic                 nn_done,
    input  logic [3:0]           nn_argmax,
    output logic [3:0]           result,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 frame_error
);

    localparam int          DATA_W   = 8;
    localparam int          WORD_W   = 32;
    localparam int          CNT_W    = 16;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIXELS - 1);

    // Elaboration-time sanity checks on the configuration.
    if (FRAC_BITS < 8 || FRAC_BITS > 23) begin : g_bad_frac_bits
        $error("image_loader: FRAC_BITS must be within 8..23");
    end
    if (THRESH < 0 || THRESH > 256) begin : g_bad_thresh
        $error("image_loader: THRESH must be within 0..256");
    end
    if (N_PIXELS < 1 || N_PIXELS > 65536) begin : g_bad_npixels
        $error("image_loader: N_PIXELS must be within 1..65536");
    end

    // -----------------------------------------------------------------------
    // Pixel conversion
    // -----------------------------------------------------------------------
    function automatic logic signed [WORD_W-1:0] to_fixed(
        input logic [DATA_W-1:0] pix
    );
`ifdef IMAGE_LOADER_BINARIZE_EN
        logic signed [WORD_W-1:0] one;
        one = 32'sd1 <<< FRAC_BITS;
        return (int'(pix) >= THRESH) ? one : 32'sd0;
`else
        logic signed [WORD_W-1:0] ext;
        // Zero extension keeps the word non-negative before the shift.
        ext = $signed({{(WORD_W - DATA_W){1'b0}}, pix});
        return ext <<< (FRAC_BITS - DATA_W);
`endif
    endfunction

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        KICK = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             load_done;   // last pixel accepted, its write is in flight
    logic             accept;
    logic             at_last;
    logic             done_seen;

    // load_done holds off pix_ready for the cycle in which the final write
    // is presented, so KICK starts only after the frame is in memory.
    assign bus.pix_ready = (state == LOAD) && !load_done;
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign at_last       = (cnt == LAST_IDX);
    assign done_seen     = (state == WAIT) && nn_done;

    assign nn_start = (state == KICK);
    assign busy     = (state == KICK) || (state == WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (load_done) begin
                    state_nxt = KICK;
                end
            end
            KICK: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (nn_done) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame bookkeeping: pixel counter, error pulse, result latch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            load_done    <= 1'b0;
            frame_error  <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            load_done   <= accept && at_last;
            frame_error <= accept && bus.pix_last && !at_last;

            if (accept && !at_last) begin
                // An early pix_last abandons the frame and restarts at 0.
                cnt <= bus.pix_last ? '0 : cnt + CNT_W'(1);
            end else if (done_seen) begin
                cnt <= '0;
            end

            if (done_seen) begin
                result       <= nn_argmax;
                result_valid <= 1'b1;
            end else if (accept && (cnt == '0)) begin
                result_valid <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage p1: memory write, one cycle after acceptance
    // -----------------------------------------------------------------------
    logic                     vld_p1;
    logic [CNT_W-1:0]         addr_p1;
    logic signed [WORD_W-1:0] data_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1 <= cnt;
            data_p1 <= to_fixed(bus.pix_data);
        end
    end

    assign bus.mem_we   = vld_p1;
    assign bus.mem_addr = addr_p1;
    assign bus.mem_data = data_p1;

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       nn_start;
    logic       nn_done = 1'b0;
    logic [3:0] nn_argmax = 4'd0;
    logic [3:0] result;
    logic       result_valid;
    logic       busy;
    logic       frame_error;

    image_loader_if bus();

    image_loader dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .nn_start     (nn_start),
        .nn_done      (nn_done),
        .nn_argmax    (nn_argmax),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observation log, written only by the monitor below.
    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int cyc       = 0;
    int last_hs   = 0;
    int start_cyc = 0;
    int starts    = 0;
    int fe_cnt    = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_data);
        end
        if (bus.pix_valid && bus.pix_ready) last_hs = cyc;
        if (nn_start) begin
            starts++;
            start_cyc = cyc;
        end
        if (frame_error) fe_cnt++;
    end

    // Expected memory word for the default FRAC_BITS=8 / THRESH=128.
    function automatic logic [31:0] exp_word(input int d);
`ifdef IMAGE_LOADER_BINARIZE_EN
        return (d >= 128) ? 32'h0000_0100 : 32'h0000_0000;
`else
        return 32'(d);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] d, input logic last);
        int n = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.pix_last  = last;
        @(negedge clk);
        while (!bus.pix_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.pix_ready) check("hs_timeout", {31'd0, bus.pix_ready}, 32'd1);
        step();
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
    endtask

    task automatic pulse_done(input logic [3:0] idx);
        nn_done   = 1'b1;
        nn_argmax = idx;
        step();
        nn_done   = 1'b0;
    endtask

    initial begin
        int base;
        int errs;
        int s0;
        int f0;
        int sent;
        int n;
        logic hs;
        logic seen_rdy;
        logic seen_we;

        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'd0;
        bus.pix_last  = 1'b0;

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        settle();
        check("rst_ready",  {31'd0, bus.pix_ready}, 32'd1);
        check("rst_we",     {31'd0, bus.mem_we},    32'd0);
        check("rst_start",  {31'd0, nn_start},      32'd0);
        check("rst_result", {28'd0, result},        32'd0);
        check("rst_rvalid", {31'd0, result_valid},  32'd0);
        check("rst_busy",   {31'd0, busy},          32'd0);
        check("rst_ferr",   {31'd0, frame_error},   32'd0);

        // Full frame of 0xFF, no stalls
        step();
        for (int i = 0; i < 784; i++) send_pix(8'hFF, (i == 783));
        repeat (4) settle();
        check("f1_writes", wr_addr.size(), 784);
        errs = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] !== 16'(i) || wr_data[i] !== exp_word(255)) errs++;
        end
        check("f1_content", errs, 0);
        check("f1_starts", starts, 1);
        check("f1_start_lat", start_cyc - last_hs, 2);
        check("f1_busy", {31'd0, busy}, 32'd1);

        // Waiting: offered pixels are refused
        base = wr_addr.size();
        seen_rdy = 1'b0;
        seen_we  = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'h55;
        for (int i = 0; i < 10; i++) begin
            settle();
            seen_rdy |= bus.pix_ready;
            seen_we  |= bus.mem_we;
        end
        check("wait_ready", {31'd0, seen_rdy}, 32'd0);
        check("wait_we",    {31'd0, seen_we},  32'd0);
        check("wait_nowr",  wr_addr.size(), base);

        // Completion with class 7
        step();
        bus.pix_valid = 1'b0;
        pulse_done(4'd7);
        settle();
        check("done_result", {28'd0, result},       32'd7);
        check("done_rvalid", {31'd0, result_valid}, 32'd1);
        check("done_ready",  {31'd0, bus.pix_ready}, 32'd1);
        check("done_busy",   {31'd0, busy},         32'd0);
        step();
        step();
        pulse_done(4'd3);
        repeat (2) settle();
        check("late_done_result", {28'd0, result},       32'd7);
        check("late_done_rvalid", {31'd0, result_valid}, 32'd1);

        // Early pix_last on the tenth pixel
        step();
        base = wr_addr.size();
        s0 = starts;
        f0 = fe_cnt;
        for (int i = 0; i < 10; i++) send_pix(8'(i), (i == 9));
        repeat (3) settle();
        check("ferr_pulses", fe_cnt - f0, 1);
        check("ferr_nostart", starts, s0);
        check("ferr_rvalid", {31'd0, result_valid}, 32'd0);
        check("ferr_result", {28'd0, result}, 32'd7);
        check("ferr_writes", wr_addr.size() - base, 10);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (wr_addr[base + i] !== 16'(i) || wr_data[base + i] !== exp_word(i)) errs++;
        end
        check("ferr_content", errs, 0);
        check("ferr_ready", {31'd0, bus.pix_ready}, 32'd1);

        // Random-gap frame, data = addr mod 256, restarting at address 0
        step();
        base = wr_addr.size();
        s0 = starts;
        sent = 0;
        n = 0;
        while (sent < 784 && n < 5000) begin
            bus.pix_valid = 1'($urandom_range(0, 1));
            bus.pix_data  = sent[7:0];
            bus.pix_last  = (sent == 783);
            @(negedge clk);
            hs = bus.pix_valid && bus.pix_ready;
            step();
            if (hs) sent++;
            n++;
        end
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        check("rand_sent", sent, 784);
        repeat (4) settle();
        check("rand_writes", wr_addr.size() - base, 784);
        errs = 0;
        for (int i = 0; i < 784 && base + i < wr_addr.size(); i++) begin
            if (wr_addr[base + i] !== 16'(i) || wr_data[base + i] !== exp_word(i % 256)) errs++;
        end
        check("rand_content", errs, 0);
        check("rand_starts", starts - s0, 1);
        step();
        pulse_done(4'd2);
        settle();
        check("rand_result", {28'd0, result}, 32'd2);
        check("rand_rvalid", {31'd0, result_valid}, 32'd1);

        // Reset mid-frame after 400 pixels
        step();
        s0 = starts;
        for (int i = 0; i < 400; i++) send_pix(8'h10, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check("midrst_result", {28'd0, result},       32'd0);
        check("midrst_rvalid", {31'd0, result_valid}, 32'd0);
        check("midrst_ready",  {31'd0, bus.pix_ready}, 32'd1);
        step();
        base = wr_addr.size();
        send_pix(8'd127, 1'b0);
        send_pix(8'd128, 1'b0);
        repeat (2) settle();
        check("midrst_addr0", {16'd0, wr_addr[base]},     32'd0);
        check("midrst_data0", wr_data[base],              exp_word(127));
        check("midrst_addr1", {16'd0, wr_addr[base + 1]}, 32'd1);
        check("midrst_data1", wr_data[base + 1],          exp_word(128));
        step();
        for (int i = 2; i < 784; i++) send_pix(8'd0, 1'b0);
        repeat (4) settle();
        check("midrst_starts", starts - s0, 1);
        check("midrst_busy", {31'd0, busy}, 32'd1);

        // Reset while waiting; the stale nn_done must be ignored
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        pulse_done(4'd9);
        repeat (2) settle();
        check("waitrst_result", {28'd0, result},       32'd0);
        check("waitrst_rvalid", {31'd0, result_valid}, 32'd0);
        check("waitrst_busy",   {31'd0, busy},         32'd0);
        check("waitrst_ready",  {31'd0, bus.pix_ready}, 32'd1);
        check("waitrst_starts", starts - s0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
